// File: rtl/field_packer_pkg.sv
// Shared types for the network-order byte packer: field sizes, FSM states
// and the packed field record carried by the output register.
package field_packer_pkg;

  localparam int MAX_BYTES = 8;
  localparam int DATA_W    = 8 * MAX_BYTES;
  localparam int BYTES_W   = 4;

  typedef enum logic [1:0] {
    SZ16   = 2'b00,
    SZ32   = 2'b01,
    SZ64   = 2'b10,
    SZ_BAD = 2'b11
  } field_size_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_FILL = 1'b1
  } fill_state_e;

  typedef struct packed {
    logic [DATA_W-1:0]  data;
    logic [BYTES_W-1:0] bytes;
    logic               last;
    logic               err;
  } field_t;

  // The illegal encoding still packs a full-width field; the caller flags it.
  function automatic int size_to_bytes(input field_size_e size);
    int n;
    case (size)
      SZ16:    n = 2;
      SZ32:    n = 4;
      SZ64:    n = 8;
      default: n = 8;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/field_out_reg.sv
// Single-entry valid/ready output slot holding one packed field.
module field_out_reg
  import field_packer_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   load,
  input  field_t in_field,
  input  logic   out_ready,
  output logic   out_valid,
  output field_t out_field
);

  logic   valid_q, valid_d;
  field_t field_q, field_d;

  // Load wins over drain so back-to-back fields keep valid high.
  always_comb begin
    valid_d = valid_q;
    field_d = field_q;
    if (load) begin
      valid_d = 1'b1;
      field_d = in_field;
    end else if (out_ready) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end
  end

  // Slot register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      field_q <= '0;
    end else begin
      valid_q <= valid_d;
      field_q <= field_d;
    end
  end

  assign out_valid = valid_q;
  assign out_field = field_q;

endmodule

// File: rtl/field_byte_packer.sv
// Gathers big-endian bytes into a right-justified host-order field of 2/4/8
// bytes, closing early on s_last, and hands it to a one-entry output slot.
module field_byte_packer #(
  parameter int MAX_BYTES = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   s_valid,
  output logic                   s_ready,
  input  logic [7:0]             s_data,
  input  logic                   s_last,
  input  logic [1:0]             cfg_size,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic [8*MAX_BYTES-1:0] m_data,
  output logic [3:0]             m_bytes,
  output logic                   m_last,
  output logic                   m_err
);
  import field_packer_pkg::*;

  fill_state_e        state_q, state_d;
  logic [3:0]         count_q, count_d;
  logic [3:0]         size_q, size_d;
  logic               err_q, err_d;
  logic [DATA_W-1:0]  acc_q, acc_d;
  logic               accept_s;
  logic               done_s;
  logic               load_s;
  field_t             field_s;
  field_t             out_field_s;

  assign s_ready  = !rst && (!m_valid || m_ready);
  assign accept_s = s_valid && s_ready;

  // Next-state, accumulate and completion detection for the field in progress.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    size_d  = size_q;
    err_d   = err_q;
    acc_d   = acc_q;
    done_s  = 1'b0;
    load_s  = 1'b0;
    field_s = '0;
    if (accept_s) begin
      case (state_q)
        ST_IDLE: begin
          size_d  = 4'(size_to_bytes(field_size_e'(cfg_size)));
          err_d   = (cfg_size == 2'b11);
          acc_d   = {{(DATA_W-8){1'b0}}, s_data};
          count_d = 4'd1;
          done_s  = s_last;
          state_d = ST_FILL;
        end
        ST_FILL: begin
          acc_d   = {acc_q[DATA_W-9:0], s_data};
          count_d = count_q + 4'd1;
          done_s  = ((count_q + 4'd1) == size_q) || s_last;
        end
        default: begin
          state_d = ST_IDLE;
          count_d = 4'd0;
        end
      endcase
      if (done_s) begin
        load_s        = 1'b1;
        field_s.data  = acc_d;
        field_s.bytes = count_d;
        field_s.last  = s_last;
        field_s.err   = err_d;
        state_d       = ST_IDLE;
        count_d       = 4'd0;
      end else begin
        load_s = 1'b0;
      end
    end else begin
      load_s = 1'b0;
    end
  end

  // Field-assembly state; a reset discards any partial field.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      count_q <= 4'd0;
      size_q  <= 4'd2;
      err_q   <= 1'b0;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      size_q  <= size_d;
      err_q   <= err_d;
      acc_q   <= acc_d;
    end
  end

  field_out_reg u_out_reg (
    .clk       (clk),
    .rst       (rst),
    .load      (load_s),
    .in_field  (field_s),
    .out_ready (m_ready),
    .out_valid (m_valid),
    .out_field (out_field_s)
  );

  assign m_data  = out_field_s.data;
  assign m_bytes = out_field_s.bytes;
  assign m_last  = out_field_s.last;
  assign m_err   = out_field_s.err;

endmodule

// File: tb/tb_field_byte_packer.sv
// Randomized and directed bench for field_byte_packer against a byte-list
// reference model that forms each field by arithmetic accumulation.
module tb_field_byte_packer;

  logic        clk;
  logic        rst;
  logic        s_valid;
  logic        s_ready;
  logic [7:0]  s_data;
  logic        s_last;
  logic [1:0]  cfg_size;
  logic        m_valid;
  logic        m_ready;
  logic [63:0] m_data;
  logic [3:0]  m_bytes;
  logic        m_last;
  logic        m_err;

  field_byte_packer dut (
    .clk      (clk),
    .rst      (rst),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .s_data   (s_data),
    .s_last   (s_last),
    .cfg_size (cfg_size),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .m_data   (m_data),
    .m_bytes  (m_bytes),
    .m_last   (m_last),
    .m_err    (m_err)
  );

  typedef struct {
    logic [63:0] data;
    int          bytes;
    logic        last;
    logic        err;
  } exp_t;

  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];
  logic [7:0] part_q[$];
  int   part_size = 0;
  logic part_err = 1'b0;
  logic last_s_ready = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference: a field is the listed bytes read as a base-256 number, MSB first.
  task automatic model_accept(input logic [7:0] d, input logic l, input logic [1:0] c);
    exp_t e;
    if (part_q.size() == 0) begin
      part_size = (c == 2'd0) ? 2 : (c == 2'd1) ? 4 : 8;
      part_err  = (c == 2'd3);
    end
    part_q.push_back(d);
    if (part_q.size() == part_size || l) begin
      e.data = 64'd0;
      foreach (part_q[i]) e.data = e.data * 64'd256 + 64'(part_q[i]);
      e.bytes = part_q.size();
      e.last  = l;
      e.err   = part_err;
      exp_q.push_back(e);
      part_q.delete();
    end
  endtask

  // One clock: drive at negedge, sample just after, model both handshakes.
  task automatic cycle(input logic v, input logic [7:0] d, input logic l,
                       input logic [1:0] c, input logic mr);
    s_valid  = v;
    s_data   = v ? d : 8'hxx;
    s_last   = l;
    cfg_size = c;
    m_ready  = mr;
    #1;
    last_s_ready = s_ready;
    chk("s_ready", 64'(s_ready), 64'(!m_valid || m_ready));
    chk("m_valid", 64'(m_valid), 64'(exp_q.size() != 0));
    if (m_valid && exp_q.size() != 0) begin
      chk("m_data",  m_data,       exp_q[0].data);
      chk("m_bytes", 64'(m_bytes), 64'(exp_q[0].bytes));
      chk("m_last",  64'(m_last),  64'(exp_q[0].last));
      chk("m_err",   64'(m_err),   64'(exp_q[0].err));
      if (m_ready) void'(exp_q.pop_front());
    end
    if (s_valid && s_ready) model_accept(d, l, c);
    @(negedge clk);
  endtask

  task automatic do_reset(input int cycles);
    rst     = 1'b1;
    s_valid = 1'b0;
    m_ready = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      #1;
      chk("rst_m_valid", 64'(m_valid), 64'd0);
      chk("rst_m_data",  m_data,       64'd0);
      chk("rst_m_bytes", 64'(m_bytes), 64'd0);
      chk("rst_m_flags", 64'({m_last, m_err}), 64'd0);
      chk("rst_s_ready", 64'(s_ready), 64'd0);
      @(negedge clk);
    end
    exp_q.delete();
    part_q.delete();
    rst = 1'b0;
  endtask

  task automatic idle(input int n, input logic mr);
    for (int i = 0; i < n; i++) cycle(1'b0, 8'h00, 1'b0, 2'd0, mr);
  endtask

  logic [7:0] bytes_a [4];
  logic [7:0] t2_bytes[4];

  initial begin
    rst = 1'b1; s_valid = 1'b0; s_data = 8'h00; s_last = 1'b0;
    cfg_size = 2'd0; m_ready = 1'b0;
    @(negedge clk);
    do_reset(2);

    // 1: 4-byte field closed by s_last on its natural boundary.
    bytes_a = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
    for (int i = 0; i < 4; i++) cycle(1'b1, bytes_a[i], (i == 3), 2'd1, 1'b0);
    #1;
    chk("t1_data",  m_data, 64'hDEADBEEF);
    chk("t1_meta",  64'({m_bytes, m_last, m_err}), 64'({4'd4, 1'b1, 1'b0}));
    idle(2, 1'b1);

    // 2: back-to-back 2-byte fields, no stall.
    t2_bytes = '{8'h12, 8'h34, 8'h56, 8'h78};
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, t2_bytes[i], 1'b0, 2'd0, 1'b1);
      chk("t2_s_ready", 64'(last_s_ready), 64'd1);
    end
    idle(2, 1'b1);

    // 3: 8-byte field then downstream stall for 5 cycles.
    for (int i = 1; i <= 8; i++) cycle(1'b1, 8'(i), 1'b0, 2'd2, 1'b0);
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, 8'hEE, 1'b0, 2'd2, 1'b0);
      chk("t3_s_ready", 64'(last_s_ready), 64'd0);
      chk("t3_data", m_data, 64'h0102030405060708);
    end
    idle(2, 1'b1);

    // 4: short field is right-justified.
    cycle(1'b1, 8'hAA, 1'b0, 2'd2, 1'b0);
    cycle(1'b1, 8'hBB, 1'b0, 2'd2, 1'b0);
    cycle(1'b1, 8'hCC, 1'b1, 2'd2, 1'b0);
    #1;
    chk("t4_data", m_data, 64'h0000000000AABBCC);
    chk("t4_meta", 64'({m_bytes, m_last}), 64'({4'd3, 1'b1}));
    idle(2, 1'b1);

    // 5: reset mid-field discards the partial field.
    cycle(1'b1, 8'h99, 1'b0, 2'd1, 1'b1);
    cycle(1'b1, 8'h98, 1'b0, 2'd1, 1'b1);
    do_reset(2);
    bytes_a = '{8'h11, 8'h22, 8'h33, 8'h44};
    for (int i = 0; i < 4; i++) cycle(1'b1, bytes_a[i], 1'b0, 2'd1, 1'b0);
    #1;
    chk("t5_data", m_data, 64'h11223344);
    idle(2, 1'b1);

    // 6: illegal size latched on first byte; mid-field change ignored.
    for (int i = 1; i <= 8; i++) cycle(1'b1, 8'(i), 1'b0, (i <= 2) ? 2'd3 : 2'd0, 1'b0);
    #1;
    chk("t6_data", m_data, 64'h0102030405060708);
    chk("t6_meta", 64'({m_bytes, m_err}), 64'({4'd8, 1'b1}));
    idle(2, 1'b1);

    // Random traffic with random backpressure and one mid-run reset.
    for (int n = 0; n < 3000; n++) begin
      if (n == 1500) do_reset(1);
      cycle(($urandom_range(0, 3) != 0), 8'($urandom), ($urandom_range(0, 9) == 0),
            2'($urandom), ($urandom_range(0, 2) != 0));
    end

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) idle(1, 1'b1);
    chk("drain_empty", 64'(exp_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
